// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: owns the dual-issue fetch PC, keeps one instruction-memory
// request in flight, arbitrates redirects and hands 64-bit packets to decode.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h1c000000,
   parameter int unsigned FETCH_STRIDE = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic        branch_flag_1,
   input  logic [31:0] branch_target_1,
   input  logic        branch_flag_2,
   input  logic [31:0] branch_target_2,
   input  logic        backend_stall,
   output logic        ireq_valid,
   output logic [31:0] ireq_addr,
   input  logic        ireq_ready,
   input  logic        iresp_valid,
   input  logic [63:0] iresp_data,
   output logic        inst_valid_o,
   output logic [31:0] inst_pc_o,
   output logic [63:0] inst_o
);

   // Handshake: a request transfers on a cycle where ireq_valid & ireq_ready are both high
   // at posedge; exactly one iresp_valid pulse returns per transferred request, at least
   // one cycle later. The decode slot transfers when inst_valid_o & ~backend_stall.

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   localparam logic [31:0] STRIDE = 32'(FETCH_STRIDE);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        kill_q, kill_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [63:0] inst_q, inst_d;

   logic        redirect;
   logic [31:0] target;
   logic        consume;

   always_comb begin
      redirect = flush | branch_flag_1 | branch_flag_2;
      if (flush) begin
         target = new_pc;
      end else if (branch_flag_1) begin
         target = branch_target_1;
      end else begin
         target = branch_target_2;
      end
      consume = inst_valid_q & ~backend_stall;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         kill_q       <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_pc_q    <= 32'h0;
         inst_q       <= 64'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         kill_q       <= kill_d;
         inst_valid_q <= inst_valid_d;
         inst_pc_q    <= inst_pc_d;
         inst_q       <= inst_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      kill_d       = kill_q;
      inst_valid_d = inst_valid_q;
      inst_pc_d    = inst_pc_q;
      inst_d       = inst_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (redirect) begin
               pc_d = target;
            end
         end
         S_REQ: begin
            // The address may move while unaccepted; once accepted under a redirect the
            // in-flight request already targets the old PC and must be killed.
            if (redirect) begin
               pc_d = target;
            end
            if (ireq_ready) begin
               state_d = S_WAIT;
               kill_d  = redirect;
            end
         end
         S_WAIT: begin
            if (iresp_valid) begin
               if (kill_q | redirect) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
                  if (redirect) begin
                     pc_d = target;
                  end
               end else begin
                  inst_valid_d = 1'b1;
                  inst_pc_d    = pc_q;
                  inst_d       = iresp_data;
                  pc_d         = pc_q + STRIDE;
                  state_d      = S_HOLD;
               end
            end else if (redirect) begin
               kill_d = 1'b1;
               pc_d   = target;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               inst_valid_d = 1'b0;
               pc_d         = target;
               state_d      = S_REQ;
            end else if (consume) begin
               inst_valid_d = 1'b0;
               state_d      = S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ireq_valid   = (state_q == S_REQ);
   assign ireq_addr    = pc_q;
   assign inst_valid_o = inst_valid_q;
   assign inst_pc_o    = inst_pc_q;
   assign inst_o       = inst_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then randomized
// traffic against a flag-based reference model compared every cycle on the falling edge.
module tb_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h1c000000;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [31:0] new_pc;
   logic        branch_flag_1;
   logic [31:0] branch_target_1;
   logic        branch_flag_2;
   logic [31:0] branch_target_2;
   logic        backend_stall;
   logic        ireq_valid;
   logic [31:0] ireq_addr;
   logic        ireq_ready;
   logic        iresp_valid;
   logic [63:0] iresp_data;
   logic        inst_valid_o;
   logic [31:0] inst_pc_o;
   logic [63:0] inst_o;

   fetch_ctrl #(.RESET_PC(RESET_PC), .FETCH_STRIDE(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .new_pc          (new_pc),
      .branch_flag_1   (branch_flag_1),
      .branch_target_1 (branch_target_1),
      .branch_flag_2   (branch_flag_2),
      .branch_target_2 (branch_target_2),
      .backend_stall   (backend_stall),
      .ireq_valid      (ireq_valid),
      .ireq_addr       (ireq_addr),
      .ireq_ready      (ireq_ready),
      .iresp_valid     (iresp_valid),
      .iresp_data      (iresp_data),
      .inst_valid_o    (inst_valid_o),
      .inst_pc_o       (inst_pc_o),
      .inst_o          (inst_o)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: what has been asked for, what is in flight, what the slot holds
   bit          model_ok = 0;
   bit          m_fresh;      // just out of reset, request not yet raised
   bit          m_req;        // request being presented
   bit          m_out;        // request accepted, response awaited
   bit          m_stale;      // awaited response belongs to an abandoned PC
   logic [31:0] m_pc;
   bit          m_sv;
   logic [31:0] m_spc;
   logic [63:0] m_sd;
   int          m_deliv = 0;

   // memory-side stimulus state
   bit          mem_busy = 0;
   logic [31:0] mem_addr;
   int          mem_lat;
   bit          resp_real;
   logic        pre_valid;
   logic [31:0] pre_addr;

   function automatic logic [63:0] pkt(input logic [31:0] a);
      logic [31:0] a4;
      a4 = a + 32'd4;
      return {a4 ^ 32'h13570000, a ^ 32'h00002468};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit          redir;
      logic [31:0] tgt;
      redir = flush | branch_flag_1 | branch_flag_2;
      tgt   = flush ? new_pc : (branch_flag_1 ? branch_target_1 : branch_target_2);
      if (rst) begin
         m_fresh = 1; m_req = 0; m_out = 0; m_stale = 0;
         m_pc = RESET_PC; m_sv = 0; m_spc = 32'h0; m_sd = 64'h0;
      end else if (m_fresh) begin
         m_fresh = 0;
         m_req   = 1;
         if (redir) m_pc = tgt;
      end else if (m_req) begin
         if (redir) m_pc = tgt;
         if (ireq_ready) begin
            m_req   = 0;
            m_out   = 1;
            m_stale = redir;
         end
      end else if (m_out) begin
         if (iresp_valid) begin
            m_out = 0;
            if (m_stale || redir) begin
               m_stale = 0;
               m_req   = 1;
               if (redir) m_pc = tgt;
            end else begin
               m_sv  = 1;
               m_spc = m_pc;
               m_sd  = iresp_data;
               m_pc  = m_pc + 32'd8;
               m_deliv++;
            end
         end else if (redir) begin
            m_stale = 1;
            m_pc    = tgt;
         end
      end else if (m_sv) begin
         if (redir) begin
            m_sv  = 0;
            m_pc  = tgt;
            m_req = 1;
         end else if (!backend_stall) begin
            m_sv  = 0;
            m_req = 1;
         end
      end
   endtask

   task automatic tick();
      pre_valid = ireq_valid;
      pre_addr  = ireq_addr;
      @(posedge clk);
      #1;
      model_step();
      model_ok = 1;
   endtask

   task automatic respond(input logic [63:0] d);
      iresp_valid = 1'b1;
      iresp_data  = d;
      tick();
      iresp_valid = 1'b0;
      iresp_data  = 64'h0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ireq_valid"}, 64'(ireq_valid), 64'd0);
      chk({tag, "_ireq_addr"}, 64'(ireq_addr), 64'(RESET_PC));
      chk({tag, "_inst_valid"}, 64'(inst_valid_o), 64'd0);
      chk({tag, "_inst_pc"}, 64'(inst_pc_o), 64'd0);
      chk({tag, "_inst"}, inst_o, 64'd0);
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (model_ok) begin
         chk("cyc_ireq_valid", 64'(ireq_valid), 64'(m_req));
         chk("cyc_ireq_addr", 64'(ireq_addr), 64'(m_pc));
         chk("cyc_inst_valid", 64'(inst_valid_o), 64'(m_sv));
         if (m_sv) begin
            chk("cyc_inst_pc", 64'(inst_pc_o), 64'(m_spc));
            chk("cyc_inst", inst_o, m_sd);
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; new_pc = 32'h0;
      branch_flag_1 = 1'b0; branch_target_1 = 32'h0;
      branch_flag_2 = 1'b0; branch_target_2 = 32'h0;
      backend_stall = 1'b0; ireq_ready = 1'b0;
      iresp_valid = 1'b0; iresp_data = 64'h0;
      tick();
      tick();
      chk_reset_outputs("reset");

      // straight-line fetch, 1-cycle latency
      rst = 1'b0; ireq_ready = 1'b1;
      tick();
      chk("seq_valid0", 64'(ireq_valid), 64'd1);
      chk("seq_addr0", 64'(ireq_addr), 64'h1c000000);
      tick();
      chk("seq_wait_valid", 64'(ireq_valid), 64'd0);
      respond(pkt(32'h1c000000));
      chk("seq_inst_valid0", 64'(inst_valid_o), 64'd1);
      chk("seq_inst_pc0", 64'(inst_pc_o), 64'h1c000000);
      chk("seq_inst0", inst_o, pkt(32'h1c000000));
      tick();
      chk("seq_addr1", 64'(ireq_addr), 64'h1c000008);
      tick();
      respond(pkt(32'h1c000008));
      chk("seq_inst_pc1", 64'(inst_pc_o), 64'h1c000008);
      chk("seq_inst1", inst_o, pkt(32'h1c000008));
      tick();
      chk("seq_addr2", 64'(ireq_addr), 64'h1c000010);

      // memory not ready for three cycles
      rst = 1'b1;
      tick();
      rst = 1'b0; ireq_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("nrdy_valid", 64'(ireq_valid), 64'd1);
         chk("nrdy_addr", 64'(ireq_addr), 64'h1c000000);
         if (i < 2) tick();
      end
      ireq_ready = 1'b1;
      tick();
      chk("nrdy_to_wait", 64'(ireq_valid), 64'd0);

      // decode back-pressure holds the slot
      backend_stall = 1'b1;
      respond(pkt(32'h1c000000));
      for (int i = 0; i < 4; i++) begin
         chk("stall_inst_valid", 64'(inst_valid_o), 64'd1);
         chk("stall_inst_pc", 64'(inst_pc_o), 64'h1c000000);
         chk("stall_inst", inst_o, pkt(32'h1c000000));
         chk("stall_no_req", 64'(ireq_valid), 64'd0);
         tick();
      end
      backend_stall = 1'b0;
      tick();
      chk("unstall_valid", 64'(ireq_valid), 64'd1);
      chk("unstall_addr", 64'(ireq_addr), 64'h1c000008);
      chk("unstall_slot", 64'(inst_valid_o), 64'd0);

      // slot-2 branch while waiting kills the response
      tick();
      branch_flag_2 = 1'b1; branch_target_2 = 32'h1c000100;
      tick();
      branch_flag_2 = 1'b0;
      tick();
      respond(pkt(32'h1c000008));
      chk("br2_slot", 64'(inst_valid_o), 64'd0);
      chk("br2_valid", 64'(ireq_valid), 64'd1);
      chk("br2_addr", 64'(ireq_addr), 64'h1c000100);

      // all three redirects together with the response: flush wins
      tick();
      flush = 1'b1; new_pc = 32'h1c008000;
      branch_flag_1 = 1'b1; branch_target_1 = 32'h1c000200;
      branch_flag_2 = 1'b1; branch_target_2 = 32'h1c000300;
      respond(pkt(32'h1c000100));
      flush = 1'b0; branch_flag_1 = 1'b0; branch_flag_2 = 1'b0;
      chk("flush_slot", 64'(inst_valid_o), 64'd0);
      chk("flush_addr", 64'(ireq_addr), 64'h1c008000);

      // reset while waiting
      tick();
      rst = 1'b1;
      tick();
      chk_reset_outputs("rst_wait");
      rst = 1'b0;
      tick();
      chk("resume_addr", 64'(ireq_addr), 64'h1c000000);
      tick();
      respond(pkt(32'h1c000000));
      chk("resume_inst_pc", 64'(inst_pc_o), 64'h1c000000);

      // PC wrap at the top of the address space
      flush = 1'b1; new_pc = 32'hfffffff8;
      tick();
      flush = 1'b0;
      chk("wrap_addr", 64'(ireq_addr), 64'hfffffff8);
      tick();
      respond(pkt(32'hfffffff8));
      chk("wrap_inst_pc", 64'(inst_pc_o), 64'hfffffff8);
      tick();
      chk("wrap_next_addr", 64'(ireq_addr), 64'h0);

      // slot 1 beats slot 2 while the request is unaccepted
      ireq_ready = 1'b0;
      branch_flag_1 = 1'b1; branch_target_1 = 32'h1c000200;
      branch_flag_2 = 1'b1; branch_target_2 = 32'h1c000300;
      tick();
      branch_flag_1 = 1'b0; branch_flag_2 = 1'b0;
      chk("prio_valid", 64'(ireq_valid), 64'd1);
      chk("prio_addr", 64'(ireq_addr), 64'h1c000200);

      // randomized traffic
      mem_busy = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         rst             = ($urandom_range(0, 299) == 0);
         flush           = ($urandom_range(0, 19) == 0);
         new_pc          = $urandom() & 32'hfffffff8;
         branch_flag_1   = ($urandom_range(0, 9) == 0);
         branch_target_1 = $urandom() & 32'hfffffff8;
         branch_flag_2   = ($urandom_range(0, 9) == 0);
         branch_target_2 = $urandom() & 32'hfffffff8;
         ireq_ready      = ($urandom_range(0, 2) != 0);
         backend_stall   = ($urandom_range(0, 2) == 0);
         resp_real       = 0;
         if (mem_busy) begin
            if (mem_lat == 0) begin
               iresp_valid = 1'b1;
               iresp_data  = pkt(mem_addr);
               resp_real   = 1;
            end else begin
               mem_lat--;
               iresp_valid = 1'b0;
               iresp_data  = {$urandom(), $urandom()};
            end
         end else begin
            iresp_valid = ($urandom_range(0, 7) == 0);
            iresp_data  = {$urandom(), $urandom()};
         end
         tick();
         if (rst) begin
            mem_busy = 0;
         end else begin
            if (resp_real) mem_busy = 0;
            if (pre_valid && ireq_ready) begin
               mem_busy = 1;
               mem_addr = pre_addr;
               mem_lat  = $urandom_range(0, 3);
            end
         end
      end
      chk("random_progress", 64'(m_deliv > 100), 64'd1);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences the dual-issue fetch PC and the instruction-memory request channel for the front end. Owns the fetch PC pair (pc, pc+4) and keeps at most one request outstanding. Arbitrates redirects with priority flush > branch slot 1 > branch slot 2, and discards stale responses. Delivers one 64-bit, two-instruction fetch packet at a time to decode through a single output slot that honours decode back-pressure.

Parameters:
RESET_PC, 32'h1c000000, fetch PC loaded on reset (slot 2 fetches RESET_PC+4)
FETCH_STRIDE, 8, PC increment per accepted packet

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  exception/ertn redirect
new_pc  in  32  flush target
branch_flag_1  in  1  slot-1 branch taken
branch_target_1  in  32  slot-1 target
branch_flag_2  in  1  slot-2 branch taken
branch_target_2  in  32  slot-2 target
backend_stall  in  1  decode cannot accept packet this cycle
ireq_valid  out  1  memory request valid
ireq_addr  out  32  request address (8-byte packet base)
ireq_ready  in  1  memory accepts request
iresp_valid  in  1  response data valid (one per accepted request, ≥1 cycle later)
iresp_data  in  64  [31:0] inst at addr, [63:32] inst at addr+4
inst_valid_o  out  1  output slot holds packet
inst_pc_o  out  32  PC of slot-1 instruction (slot 2 = +4)
inst_o  out  64  packet instructions

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, pc=RESET_PC, kill=0, ireq_valid=0, ireq_addr=RESET_PC, inst_valid_o=0, inst_pc_o=0, inst_o=0. Reset overrides every other input, including mid-request. Any response to a pre-reset request is never delivered; the memory side is reset together with this block.
- redirect = flush | branch_flag_1 | branch_flag_2. Target = new_pc if flush, else branch_target_1 if branch_flag_1, else branch_target_2.
- Any redirect: pc<=target next cycle and inst_valid_o<=0, so the held packet is dropped.
- Consume = inst_valid_o & ~backend_stall. inst_valid_o/inst_pc_o/inst_o hold stable while inst_valid_o & backend_stall.
- ireq_valid = (state==REQ). ireq_addr = pc, registered.
- States:
  - IDLE: entered only from reset; always goes to REQ the next cycle, applying a redirect if present.
  - REQ: ireq_valid=1.
    - ireq_ready & ~redirect: go to WAIT, kill=0.
    - ireq_ready & redirect: go to WAIT, kill=1 (accepted request is stale), pc=target.
    - ~ireq_ready & redirect: stay in REQ, pc=target. ireq_addr may change while the request is unaccepted; the memory interface tolerates this.
  - WAIT: ireq_valid=0.
    - iresp_valid & (kill | redirect): discard response, kill<=0, go to REQ. pc=target if redirect.
    - iresp_valid & ~kill & ~redirect: inst_valid_o<=1, inst_pc_o<=pc, inst_o<=iresp_data, pc<=pc+FETCH_STRIDE, go to HOLD.
    - ~iresp_valid & redirect: kill<=1, pc=target.
  - HOLD: slot full.
    - Consume: go to REQ; inst_valid_o<=0 unless refilled.
    - Redirect: slot cleared, go to REQ.
- Only one outstanding request; a new request issues only when the slot is empty. A response therefore never finds the slot occupied.
- PC arithmetic is modulo 2^32; 32'hFFFFFFF8+8 wraps to 0.
- iresp_valid outside WAIT is ignored.

Test Plan:
- Reset, ireq_ready=1, 1-cycle response latency, backend_stall=0 -> ireq_addr sequence 1c000000, 1c000008, 1c000010. inst_pc_o matches each address. inst_o equals iresp_data.
- ireq_ready held 0 for 3 cycles -> ireq_valid=1 and ireq_addr=1c000000 stable for all 3 cycles. Transition to WAIT on the first ready cycle.
- backend_stall=1 for 4 cycles with packet at 1c000000 -> outputs frozen, no new request. Stall release -> REQ for 1c000008 issues the next cycle.
- branch_flag_2=1 (target 1c000100) during WAIT, response arrives 2 cycles later -> response discarded, inst_valid_o stays 0, next ireq_addr=1c000100.
- flush (new_pc=1c008000), branch_flag_1 (1c000200) and branch_flag_2 asserted in the same cycle as iresp_valid -> response dropped, next ireq_addr=1c008000.
- rst asserted while in WAIT -> next cycle all outputs at reset values. Later fetches resume from 1c000000.
